// File: rtl/game_pkg.sv
// Shared screen geometry and the shot slot record used by the game blocks.
package game_pkg;

   localparam int MAX_X    = 640;
   localparam int MAX_Y    = 475;
   localparam int COORD_W  = 10;
   localparam int PLAYER_W = 20;

   typedef logic [COORD_W-1:0] coord_t;

   typedef struct packed {
      logic   active;
      coord_t x;
      coord_t y;
   } shot_t;

endpackage

// File: rtl/shot_alloc.sv
// Lowest-index free slot finder; free_sel is one-hot or all zero.
module shot_alloc
   import game_pkg::*;
#(
   parameter int NUM_SHOTS = 4
) (
   input  logic [NUM_SHOTS-1:0] active,
   output logic                 free_valid,
   output logic [NUM_SHOTS-1:0] free_sel
);

   // Scan from slot 0 upward and grab the first inactive one.
   always_comb begin
      free_valid = 1'b0;
      free_sel   = '0;
      for (int i = 0; i < NUM_SHOTS; i++) begin
         if (!active[i] && !free_valid) begin
            free_sel[i] = 1'b1;
            free_valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/shot_scheduler.sv
// Shot slot pool: fire request capture, spawn at the muzzle, upward motion per
// ref_tick, retirement at the top of the screen and per-pixel draw.
module shot_scheduler
   import game_pkg::*;
#(
   parameter int NUM_SHOTS  = 4,
   parameter int SHOT_W     = 2,
   parameter int SHOT_H     = 6,
   parameter int SHOT_SPEED = 8,
   parameter int COOLDOWN   = 6,
   parameter int X_OFF      = 9
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ref_tick,
   input  logic                 fire,
   input  logic [COORD_W-1:0]   player_left,
   input  logic [COORD_W-1:0]   player_up,
   input  logic [COORD_W-1:0]   hc,
   input  logic [COORD_W-1:0]   vc,
   output logic                 shot_draw,
   output logic [NUM_SHOTS-1:0] shots_active,
   output logic                 fire_ack,
   output logic                 fire_drop
);

   // A zero-length cooldown still needs a one-bit counter.
   localparam int CD_W = (COOLDOWN > 1) ? $clog2(COOLDOWN + 1) : 1;

   logic                 fire_q;
   logic                 pend;
   logic [CD_W-1:0]      cooldown;
   logic                 fire_edge;
   logic                 req;
   logic                 can_spawn;
   logic                 spawn;
   logic                 drop;
   logic                 free_valid;
   logic [NUM_SHOTS-1:0] free_sel;
   logic [NUM_SHOTS-1:0] hit;
   coord_t               spawn_x;
   coord_t               spawn_y;

   assign fire_edge = fire & ~fire_q;
   assign req       = pend | fire_edge;

   shot_alloc #(
      .NUM_SHOTS (NUM_SHOTS)
   ) u_alloc (
      .active     (shots_active),
      .free_valid (free_valid),
      .free_sel   (free_sel)
   );

   // Spawn decision uses pre-tick slot state, so a retiring slot is not free yet.
   always_comb begin
      can_spawn = (cooldown == '0) && free_valid && (player_up >= COORD_W'(SHOT_H));
      spawn     = ref_tick && req && can_spawn;
      drop      = ref_tick && req && !can_spawn;
      spawn_x   = player_left + COORD_W'(X_OFF);
      spawn_y   = player_up - COORD_W'(SHOT_H);
   end

   // Fire edge capture, pending request, cooldown timer and result pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         fire_q    <= 1'b0;
         pend      <= 1'b0;
         cooldown  <= '0;
         fire_ack  <= 1'b0;
         fire_drop <= 1'b0;
      end else begin
         fire_q    <= fire;
         fire_ack  <= spawn;
         fire_drop <= drop;
         if (ref_tick) begin
            pend <= 1'b0;
            if (spawn)
               cooldown <= CD_W'(COOLDOWN);
            else if (cooldown != '0)
               cooldown <= cooldown - CD_W'(1);
         end else if (fire_edge) begin
            pend <= 1'b1;
         end
      end
   end

   for (genvar i = 0; i < NUM_SHOTS; i++) begin : g_slot
      shot_t            slot_q;
      logic [COORD_W:0] hc_w;
      logic [COORD_W:0] vc_w;
      logic [COORD_W:0] x_w;
      logic [COORD_W:0] y_w;

      // Slot update: a fresh spawn takes priority and does not move this tick.
      always_ff @(posedge clk) begin
         if (rst) begin
            slot_q <= '0;
         end else if (ref_tick) begin
            if (spawn && free_sel[i]) begin
               slot_q.active <= 1'b1;
               slot_q.x      <= spawn_x;
               slot_q.y      <= spawn_y;
            end else if (slot_q.active) begin
               if (slot_q.y >= COORD_W'(SHOT_SPEED))
                  slot_q.y <= slot_q.y - COORD_W'(SHOT_SPEED);
               else
                  slot_q.active <= 1'b0;
            end
         end
      end

      assign shots_active[i] = slot_q.active;

      // Widened compare so x+SHOT_W near the right edge cannot wrap.
      assign hc_w   = {1'b0, hc};
      assign vc_w   = {1'b0, vc};
      assign x_w    = {1'b0, slot_q.x};
      assign y_w    = {1'b0, slot_q.y};
      assign hit[i] = slot_q.active
                      && (hc_w >= x_w) && (hc_w < x_w + (COORD_W+1)'(SHOT_W))
                      && (vc_w >= y_w) && (vc_w < y_w + (COORD_W+1)'(SHOT_H));
   end

   assign shot_draw = |hit;

endmodule

// File: tb/tb_shot_scheduler.sv
// Directed bench for shot_scheduler: one default instance and one with no cooldown
// share the same stimulus.
module tb_shot_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic       ref_tick;
   logic       fire;
   logic [9:0] player_left;
   logic [9:0] player_up;
   logic [9:0] hc;
   logic [9:0] vc;

   logic       a_draw, a_ack, a_drop;
   logic [3:0] a_act;
   logic       b_draw, b_ack, b_drop;
   logic [3:0] b_act;

   int n_cmp = 0;
   int n_err = 0;
   int b_acks;
   int b_drops;

   always #5 clk = ~clk;

   shot_scheduler dut_a (
      .clk          (clk),
      .rst          (rst),
      .ref_tick     (ref_tick),
      .fire         (fire),
      .player_left  (player_left),
      .player_up    (player_up),
      .hc           (hc),
      .vc           (vc),
      .shot_draw    (a_draw),
      .shots_active (a_act),
      .fire_ack     (a_ack),
      .fire_drop    (a_drop)
   );

   shot_scheduler #(.COOLDOWN(0)) dut_b (
      .clk          (clk),
      .rst          (rst),
      .ref_tick     (ref_tick),
      .fire         (fire),
      .player_left  (player_left),
      .player_up    (player_up),
      .hc           (hc),
      .vc           (vc),
      .shot_draw    (b_draw),
      .shots_active (b_act),
      .fire_ack     (b_ack),
      .fire_drop    (b_drop)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_tick();
      ref_tick = 1'b1;
      step();
      ref_tick = 1'b0;
   endtask

   task automatic tick_fire();
      fire     = 1'b1;
      ref_tick = 1'b1;
      step();
      ref_tick = 1'b0;
      fire     = 1'b0;
   endtask

   task automatic probe_a(input string tag, input int h, input int v, input logic exp);
      hc = 10'(h);
      vc = 10'(v);
      #1;
      chk(tag, {31'b0, a_draw}, {31'b0, exp});
   endtask

   task automatic probe_b(input string tag, input int h, input int v, input logic exp);
      hc = 10'(h);
      vc = 10'(v);
      #1;
      chk(tag, {31'b0, b_draw}, {31'b0, exp});
   endtask

   initial begin
      rst = 1'b1; ref_tick = 1'b0; fire = 1'b0;
      player_left = 10'd100; player_up = 10'd200; hc = '0; vc = '0;
      step(); step(); step();
      rst = 1'b0;
      step();

      // reset state
      chk("rst_act", a_act, 4'b0000);
      chk("rst_ack", a_ack, 1'b0);
      chk("rst_drop", a_drop, 1'b0);
      probe_a("rst_draw", 0, 0, 1'b0);

      // basic spawn: edge before the tick, served on tick t1
      fire = 1'b1; step(); fire = 1'b0;
      chk("pend_no_ack", a_ack, 1'b0);
      chk("pend_no_act", a_act, 4'b0000);
      step();
      do_tick();
      chk("t1_ack", a_ack, 1'b1);
      chk("t1_drop", a_drop, 1'b0);
      chk("t1_act", a_act, 4'b0001);
      probe_a("draw_109_194", 109, 194, 1'b1);
      probe_a("draw_110_199", 110, 199, 1'b1);
      probe_a("draw_111_194", 111, 194, 1'b0);
      probe_a("draw_109_200", 109, 200, 1'b0);
      probe_a("draw_108_194", 108, 194, 1'b0);
      probe_a("draw_109_193", 109, 193, 1'b0);
      step();
      chk("ack_width", a_ack, 1'b0);
      chk("ack_width_drop", a_drop, 1'b0);

      // t2: move up by 8
      do_tick();
      probe_a("t2_y186", 109, 186, 1'b1);
      probe_a("t2_y191", 109, 191, 1'b1);
      probe_a("t2_y192", 109, 192, 1'b0);
      step();

      // t3: fire during cooldown
      tick_fire();
      chk("t3_a_drop", a_drop, 1'b1);
      chk("t3_a_ack", a_ack, 1'b0);
      chk("t3_a_act", a_act, 4'b0001);
      chk("t3_b_ack", b_ack, 1'b1);
      chk("t3_b_act", b_act, 4'b0011);
      step();
      chk("drop_width", a_drop, 1'b0);

      do_tick(); step();
      do_tick(); step();
      do_tick(); step();

      // t7: cooldown is at 1, still refused
      tick_fire();
      chk("t7_a_drop", a_drop, 1'b1);
      chk("t7_b_act", b_act, 4'b0111);
      step();

      // t8: cooldown expired
      tick_fire();
      chk("t8_a_ack", a_ack, 1'b1);
      chk("t8_a_act", a_act, 4'b0011);
      chk("t8_b_act", b_act, 4'b1111);
      probe_a("t8_slot1", 109, 194, 1'b1);
      probe_a("t8_slot0", 109, 138, 1'b1);
      probe_a("t8_slot0_above", 109, 137, 1'b0);
      step();

      // t9: A in cooldown, B pool full
      tick_fire();
      chk("t9_a_drop", a_drop, 1'b1);
      chk("t9_b_drop", b_drop, 1'b1);
      chk("t9_b_ack", b_ack, 1'b0);
      chk("t9_b_act", b_act, 4'b1111);
      step();

      // reset mid-flight with a tick and fire present
      rst = 1'b1; ref_tick = 1'b1; fire = 1'b1;
      step();
      rst = 1'b0; ref_tick = 1'b0; fire = 1'b0;
      chk("midrst_a_act", a_act, 4'b0000);
      chk("midrst_b_act", b_act, 4'b0000);
      chk("midrst_ack", a_ack, 1'b0);
      step();
      do_tick();
      chk("post_rst_no_ack", b_ack, 1'b0);
      chk("post_rst_no_drop", b_drop, 1'b0);
      step();

      // player too close to the top
      player_up = 10'd3;
      tick_fire();
      chk("low_up_drop", b_drop, 1'b1);
      chk("low_up_ack", b_ack, 1'b0);
      chk("low_up_act", b_act, 4'b0000);
      step();

      // fire held across 10 ticks
      player_up = 10'd200;
      b_acks = 0; b_drops = 0;
      fire = 1'b1; step();
      for (int i = 0; i < 10; i++) begin
         do_tick();
         b_acks  += int'(b_ack);
         b_drops += int'(b_drop);
         step();
         b_acks  += int'(b_ack);
         b_drops += int'(b_drop);
      end
      fire = 1'b0;
      chk("held_acks", b_acks, 1);
      chk("held_drops", b_drops, 0);
      chk("held_act", b_act, 4'b0001);
      probe_b("held_y122", 109, 122, 1'b1);
      probe_b("held_y121", 109, 121, 1'b0);

      // back-to-back ticks: two full moves
      ref_tick = 1'b1; step(); step(); ref_tick = 1'b0;
      probe_b("b2b_y106", 109, 106, 1'b1);
      probe_b("b2b_y105", 109, 105, 1'b0);
      probe_b("b2b_y112", 109, 112, 1'b0);
      step();

      // pool exhaustion and retire/reuse on B
      rst = 1'b1; step(); rst = 1'b0; step();
      tick_fire(); chk("pool_1", b_act, 4'b0001); step();
      tick_fire(); chk("pool_2", b_act, 4'b0011); step();
      tick_fire(); chk("pool_3", b_act, 4'b0111); step();
      player_up = 10'd11;
      tick_fire(); chk("pool_4", b_act, 4'b1111);
      probe_b("low_shot_draw", 109, 5, 1'b1);
      step();
      player_up = 10'd200;
      tick_fire();
      chk("retire_drop", b_drop, 1'b1);
      chk("retire_ack", b_ack, 1'b0);
      chk("retire_act", b_act, 4'b0111);
      probe_b("retired_draw", 109, 5, 1'b0);
      step();
      tick_fire();
      chk("reuse_ack", b_ack, 1'b1);
      chk("reuse_act", b_act, 4'b1111);
      probe_b("reuse_draw", 110, 199, 1'b1);
      step();

      // x near the right edge: draw compare must not wrap
      rst = 1'b1; step(); rst = 1'b0; step();
      player_left = 10'd1014;
      tick_fire();
      chk("edge_ack", b_ack, 1'b1);
      probe_b("edge_draw_1023", 1023, 194, 1'b1);
      probe_b("edge_draw_0", 0, 194, 1'b0);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/shot_scheduler.md
# shot_scheduler

Projectile slot controller for the player's shoot mechanic. It owns a fixed pool of shot slots and services fire requests from the game input logic. It spawns each shot at the player's muzzle, advances all live shots upward once per `ref_tick`, and retires them at the top of the screen. It sits beside `Player`, shares its `ref_tick`, `hc`/`vc` and player position, and drives a per-pixel `shot_draw` signal to the VGA colour mux.

## Interface
- `NUM_SHOTS`, default 4: number of shot slots, range 1–8.
- `SHOT_W`, default 2: shot width in pixels.
- `SHOT_H`, default 6: shot height in pixels.
- `SHOT_SPEED`, default 8: pixels moved up per `ref_tick`.
- `COOLDOWN`, default 6: `ref_tick`s after a spawn during which further fires are refused.
- `X_OFF`, default 9: muzzle x offset from `player_left`.
- `clk` in 1: system clock, the only clock.
- `rst` in 1: reset; synchronous, active-high.
- `ref_tick` in 1: one-cycle frame/refresh strobe, the same one `Player` uses.
- `fire` in 1: level fire button, already synchronised; only its rising edge matters.
- `player_left` in 10: player's current left border.
- `player_up` in 10: player's current upper border.
- `hc` in 10: current VGA horizontal pixel coordinate.
- `vc` in 10: current VGA vertical pixel coordinate.
- `shot_draw` out 1: combinational; 1 when (`hc`,`vc`) lies inside any live shot.
- `shots_active` out NUM_SHOTS: registered; bit i high means slot i is live.
- `fire_ack` out 1: registered one-cycle pulse when a shot is spawned.
- `fire_drop` out 1: registered one-cycle pulse when a fire request is refused.

## Operation
- **Edge detect.** `fire_q` holds `fire` delayed by one cycle. `fire_edge = fire & ~fire_q`.
- **Pending flag.** `pend` is set by `fire_edge` and cleared on service.
  - Service happens on any `ref_tick` cycle where `pend | fire_edge` is true.
  - Multiple edges between ticks collapse to one request.
- **Per-slot state.** Each slot holds `active`, `x[9:0]` and `y[9:0]`, where (`x`,`y`) is the top-left corner.
- **On a `ref_tick` cycle, all updates use pre-tick values:**
  - **Move.** Every active slot with `y >= SHOT_SPEED` gets `y <= y - SHOT_SPEED`. An active slot with `y < SHOT_SPEED` is retired (`active <= 0`).
  - **Service a request.** Spawn if `cooldown == 0`, a slot is free (pre-tick `active == 0`), and `player_up >= SHOT_H`.
    - Spawning takes the lowest-index free slot and sets `x = player_left + X_OFF` (10-bit truncation) and `y = player_up - SHOT_H`.
    - On spawn: `cooldown <= COOLDOWN`, `fire_ack` pulses next cycle.
    - If any condition fails, the request is discarded and `fire_drop` pulses next cycle.
    - Either way, `pend` clears.
  - **New shot.** The slot spawned on this tick does not move on this tick.
  - **Retiring slot.** A slot that retires on this tick is not free for a spawn in the same tick.
  - **Cooldown.** When no spawn occurs, `cooldown` decrements and saturates at 0.
- **Off-tick cycles.** Slot state and `cooldown` hold. Only `fire_q` and `pend` update.
- **Draw.** `shot_draw` = OR over active slots of (`x <= hc < x+SHOT_W`) & (`y <= vc < y+SHOT_H`). Compare in 11 bits so there is no wrap.
- **Reset.** All slots inactive with x=y=0, `cooldown`=0, `pend`=0, `fire_q`=0, `fire_ack`=0, `fire_drop`=0. Reset mid-flight kills all shots immediately.

## Timing
- **Fire latency.**
  - If `fire_edge` falls in the tick cycle T: `shots_active` bit and `fire_ack` are visible at T+1.
  - If the edge is earlier: response at the next tick cycle + 1.
- **Pulse width.** `fire_ack` and `fire_drop` are exactly one cycle and mutually exclusive.
- **Draw path.** `shot_draw` is combinational from `hc`/`vc` and registered slot state, with zero cycles of added latency, matching `Player`'s `player_draw`.
- **Tick spacing.** Back-to-back `ref_tick` cycles are legal; each one is a full move/service step.
- **Mid-tick changes.** A `ref_tick` during reset is ignored.

## Structure
- **Shared package `game_pkg`.** Holds `MAX_X`=640, `MAX_Y`=475, the coordinate width constant (10), and `PLAYER_W`=20. `Player` and `shot_scheduler` share these.
- **Sub-module `shot_alloc`.** Combinational lowest-free-slot priority encoder. Inputs: `active` vector. Outputs: `free_valid` and a one-hot `free_sel`.
- **Slot registers.** Slot arrays live in `shot_scheduler`, with one generate loop per slot.

## Test plan
- **Basic spawn.** Reset, `player_left`=100, `player_up`=200, fire edge, then tick → `fire_ack`, `shots_active`=0001, slot0 x=109, y=194. Next tick → y=186.
- **Cooldown.** Fire on consecutive ticks → first acked, second `fire_drop`. After 6 ticks with no fire, the next fire is acked.
- **Pool exhausted.** Use `COOLDOWN`=0 and 5 fires on 5 ticks → slots 0–3 fill in order, fifth gives `fire_drop`, `shots_active`=1111.
- **Retire and reuse.** Shot at y=5 on a tick → retired, and a fire on that same tick with the pool full is dropped. On the next tick the fire takes the freed slot.
- **Draw window.** Shot at x=109, y=194 → `shot_draw`=1 at (109,194) and (110,199); 0 at (111,194), (109,200) and (108,194).
- **Edge cases.**
  - `player_up`=3 with fire → drop.
  - Fire held high across 10 ticks → exactly one request.
  - `rst` asserted with 3 live shots → `shots_active`=0000 the next cycle.
